// File: rtl/demux14_dispatch_if.sv
// Handshake bundle for the 1-to-4 dispatch block: one input stream and four output channels.
// The master side is the producer and the consumers; the slave side is the dispatcher.
interface demux14_dispatch_if #(
    parameter int W = 4
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   select;
    logic [W-1:0] out1;
    logic [W-1:0] out2;
    logic [W-1:0] out3;
    logic [W-1:0] out4;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;

    modport master (
        output in_data, in_valid, select, out_ready,
        input  in_ready, out1, out2, out3, out4, out_valid
    );

    modport slave (
        input  in_data, in_valid, select, out_ready,
        output in_ready, out1, out2, out3, out4, out_valid
    );
endinterface

// File: rtl/demux14_dispatch.sv
// Registered 1-to-4 demultiplexer with a single-entry holding register per channel.
// Optional per-channel saturating accept counters are built when DEMUX_CNT_EN is defined.
//
// state    | meaning (per channel)
// ---------+--------------------------------------------
// ST_EMPTY | holding register free, out_valid[k]=0
// ST_FULL  | holding register has a word, out_valid[k]=1
module demux14_dispatch #(
    parameter int W = 4
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux14_dispatch_if.slave    bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]     cnt1,
    output logic [CNT_W-1:0]     cnt2,
    output logic [CNT_W-1:0]     cnt3,
    output logic [CNT_W-1:0]     cnt4
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    chan_state_t  r_state [4];
    chan_state_t  w_state_nxt [4];
    logic [W-1:0] r_data [4];
    logic [3:0]   w_valid;
    logic [3:0]   w_load;
    logic         w_in_ready;
    logic         w_accept;

    always_comb begin
        w_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_valid[k] = (r_state[k] == ST_FULL);
        end
    end

    // A full channel can still accept when its consumer drains in the same cycle.
    always_comb begin
        w_in_ready = !w_valid[bus.select] | bus.out_ready[bus.select];
        w_accept   = bus.in_valid & w_in_ready;
        w_load     = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_state_nxt[k] = r_state[k];
            if (w_accept && (bus.select == 2'(k))) begin
                w_load[k]      = 1'b1;
                w_state_nxt[k] = ST_FULL;
            end else if ((r_state[k] == ST_FULL) && bus.out_ready[k]) begin
                w_state_nxt[k] = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= ST_EMPTY;
                r_data[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= w_state_nxt[k];
                if (w_load[k]) begin
                    r_data[k] <= bus.in_data;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out1      = r_data[0];
    assign bus.out2      = r_data[1];
    assign bus.out3      = r_data[2];
    assign bus.out4      = r_data[3];

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign cnt1 = r_cnt[0];
    assign cnt2 = r_cnt[1];
    assign cnt3 = r_cnt[2];
    assign cnt4 = r_cnt[3];
`endif

endmodule
